// File: rtl/stonyman_sequencer.sv
// Stonyman pixel-addressing sequencer: walks row/col pointers, settles, and hands each pixel to the ADC.
// Optional feature macro STONYMAN_SUBSAMPLE_EN: capture every second row/column using double INCV/INCP pulses.
module stonyman_sequencer #(
  parameter int unsigned ROWS          = 112,
  parameter int unsigned COLS          = 112,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       adc_capture_done,
  output logic       adc_capture_start,
  output logic       resv,
  output logic       incv,
  output logic       resp,
  output logic       incp,
  output logic [6:0] row,
  output logic [6:0] col,
  output logic       frame_busy,
  output logic       frame_done
);

  localparam int unsigned PTR_W = 7;
  localparam int unsigned CMP_W = PTR_W + 1;
  localparam int unsigned TMR_W = 16;
`ifdef STONYMAN_SUBSAMPLE_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif
  localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CMP_W-1:0] ROW_LAST  = CMP_W'(ROWS - 1);
  localparam logic [CMP_W-1:0] COL_LAST  = CMP_W'(COLS - 1);
  localparam logic [CMP_W-1:0] STEP_CMP  = CMP_W'(STEP);
  localparam logic [PTR_W-1:0] STEP_PTR  = PTR_W'(STEP);

  typedef enum logic [3:0] {
    IDLE, RST_ROW, RST_COL, SETTLE, CAPTURE, WAIT_DONE, INC_COL, INC_ROW, DONE
  } state_t;

  state_t             state, state_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [PTR_W-1:0]   row_d, col_d;
  logic               tmr_zero, col_more, row_more, pulse_last, pulse_on_d;
  logic               cap_d, resv_d, resp_d, incv_d, incp_d, busy_d, done_d;
`ifdef STONYMAN_SUBSAMPLE_EN
  // Increment phase: 0 = first pulse, 1 = low gap, 2 = second pulse.
  logic [1:0]         ph, ph_d;
  assign pulse_last = (ph == 2'd2);
  assign pulse_on_d = (ph_d != 2'd1);
`else
  assign pulse_last = 1'b1;
  assign pulse_on_d = 1'b1;
`endif

  assign tmr_zero = (timer == '0);
  assign col_more = (({1'b0, col} + STEP_CMP) <= COL_LAST);
  assign row_more = (({1'b0, row} + STEP_CMP) <= ROW_LAST);

  // Next-state, timer, pointer and output decode.
  always_comb begin
    state_d = state;
    timer_d = timer;
    row_d   = row;
    col_d   = col;
`ifdef STONYMAN_SUBSAMPLE_EN
    ph_d    = ph;
`endif
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_d = RST_ROW;
          timer_d = PULSE_LD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      RST_ROW: begin
        if (tmr_zero) begin
          state_d = RST_COL;
          timer_d = PULSE_LD;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
      RST_COL: begin
        if (tmr_zero) begin
          state_d = SETTLE;
          timer_d = SETTLE_LD;
          col_d   = '0;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
      SETTLE: begin
        if (tmr_zero) state_d = CAPTURE;
        else          timer_d = timer - TMR_W'(1);
      end
      CAPTURE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (adc_capture_done) begin
          timer_d = PULSE_LD;
`ifdef STONYMAN_SUBSAMPLE_EN
          ph_d    = 2'd0;
`endif
          if (col_more)      state_d = INC_COL;
          else if (row_more) state_d = INC_ROW;
          else               state_d = DONE;
        end
      end
      INC_COL, INC_ROW: begin
        if (!tmr_zero) begin
          timer_d = timer - TMR_W'(1);
        end else if (!pulse_last) begin
          timer_d = PULSE_LD;
`ifdef STONYMAN_SUBSAMPLE_EN
          ph_d    = ph + 2'd1;
`endif
        end else if (state == INC_COL) begin
          state_d = SETTLE;
          timer_d = SETTLE_LD;
          col_d   = col + STEP_PTR;
        end else begin
          state_d = RST_COL;
          timer_d = PULSE_LD;
          row_d   = row + STEP_PTR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    resv_d = (state_d == RST_ROW);
    resp_d = (state_d == RST_COL);
    incp_d = (state_d == INC_COL) && pulse_on_d;
    incv_d = (state_d == INC_ROW) && pulse_on_d;
    cap_d  = (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      timer             <= '0;
      row               <= '0;
      col               <= '0;
      adc_capture_start <= 1'b0;
      resv              <= 1'b0;
      resp              <= 1'b0;
      incv              <= 1'b0;
      incp              <= 1'b0;
      frame_busy        <= 1'b0;
      frame_done        <= 1'b0;
`ifdef STONYMAN_SUBSAMPLE_EN
      ph                <= 2'd0;
`endif
    end else begin
      state             <= state_d;
      timer             <= timer_d;
      row               <= row_d;
      col               <= col_d;
      adc_capture_start <= cap_d;
      resv              <= resv_d;
      resp              <= resp_d;
      incv              <= incv_d;
      incp              <= incp_d;
      frame_busy        <= busy_d;
      frame_done        <= done_d;
`ifdef STONYMAN_SUBSAMPLE_EN
      ph                <= ph_d;
`endif
    end
  end

endmodule
